// File: rtl/char_xlat_pkg.sv
// Shared types for the character translator: FSM states, rule slot layout,
// reset contents of the rule table and a saturating counter helper.
package char_xlat_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic {
        S_NORM = 1'b0,
        S_ESC  = 1'b1
    } xlat_state_e;

    typedef struct packed {
        logic              en;
        logic [CHAR_W-1:0] match;
        logic [CHAR_W-1:0] replace;
    } rule_t;

    localparam logic              RULE0_EN      = 1'b1;
    localparam logic [CHAR_W-1:0] RULE0_MATCH   = 8'h03;
    localparam logic [CHAR_W-1:0] RULE0_REPLACE = 8'h62;

    localparam rule_t RULE0_RESET = {RULE0_EN, RULE0_MATCH, RULE0_REPLACE};
    localparam rule_t RULE_EMPTY  = '0;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/char_rule_match.sv
// Combinational priority matcher: the lowest-index enabled rule whose match
// field equals the character supplies the replacement.
module char_rule_match
    import char_xlat_pkg::*;
#(
    parameter int NUM_RULES = 4
) (
    input  rule_t [NUM_RULES-1:0] rules,
    input  logic  [CHAR_W-1:0]    ch,
    output logic                  hit,
    output logic  [CHAR_W-1:0]    replace
);

    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        replace = '0;
        // Walking from the top down lets lower indices overwrite higher ones.
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (rules[i].en && (rules[i].match == ch)) begin
                hit     = 1'b1;
                replace = rules[i].replace;
            end
        end
    end

endmodule

// File: rtl/seq_char_translator.sv
// Streaming character translator with escape handling and a runtime rule table.
// Optional feature: define CHAR_XLAT_STATS_EN to add the match_count output.
module seq_char_translator
    import char_xlat_pkg::*;
#(
    parameter int                 DATA_W         = 8,
    parameter int                 NUM_RULES      = 4,
    parameter bit                 PASS_UNMATCHED = 1'b1,
    parameter logic [DATA_W-1:0]  DEFAULT_CHAR   = 8'h63,
    parameter logic [DATA_W-1:0]  ESC_CHAR       = 8'h1B,
    localparam int                IDX_W          = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_char,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_char,

    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [DATA_W-1:0] cfg_match,
    input  logic [DATA_W-1:0] cfg_replace
`ifdef CHAR_XLAT_STATS_EN
    ,
    output logic [15:0]       match_count
`endif
);

    if (DATA_W != CHAR_W) begin : g_width_check
        $error("seq_char_translator: DATA_W must equal char_xlat_pkg::CHAR_W");
    end

    xlat_state_e            state_q;
    xlat_state_e            state_d;
    rule_t [NUM_RULES-1:0]  rules_q;
    logic                   accept;
    logic                   cfg_idx_ok;
    logic                   rule_hit;
    logic [DATA_W-1:0]      rule_replace;
    logic                   emit;
    logic [DATA_W-1:0]      emit_char;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign cfg_idx_ok = (32'(cfg_idx) < NUM_RULES);

    char_rule_match #(
        .NUM_RULES (NUM_RULES)
    ) u_match (
        .rules   (rules_q),
        .ch      (in_char),
        .hit     (rule_hit),
        .replace (rule_replace)
    );

    // NOTE: the rule table is a handful of flops, not a RAM, so it is reset
    // to its documented defaults like any other state.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                rules_q[i] <= (i == 0) ? RULE0_RESET : RULE_EMPTY;
            end
        end else if (cfg_we && cfg_idx_ok) begin
            // The char accepted this cycle already used the old entry.
            rules_q[cfg_idx] <= {cfg_en, cfg_match, cfg_replace};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_NORM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_char = in_char;
        if (accept) begin
            case (state_q)
                S_NORM: begin
                    if (in_char == ESC_CHAR) begin
                        state_d = S_ESC;
                    end else begin
                        emit = 1'b1;
                        if (rule_hit) begin
                            emit_char = rule_replace;
                        end else if (!PASS_UNMATCHED) begin
                            emit_char = DEFAULT_CHAR;
                        end
                    end
                end
                S_ESC: begin
                    emit    = 1'b1;
                    state_d = S_NORM;
                end
                default: state_d = S_NORM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_valid <= 1'b0;
            out_char  <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_char  <= emit_char;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CHAR_XLAT_STATS_EN
    logic rule_xlat;

    assign rule_xlat = accept && (state_q == S_NORM) && (in_char != ESC_CHAR) && rule_hit;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            match_count <= '0;
        end else if (rule_xlat) begin
            match_count <= sat_inc16(match_count);
        end
    end
`endif

endmodule

// File: tb/tb_seq_char_translator.sv
// Bench for seq_char_translator: directed scenarios plus randomized traffic
// scored against a behavioural model, on pass-through and default-char builds.
module tb_seq_char_translator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = '0;
    logic       out_ready = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic       cfg_en = 1'b0;
    logic [7:0] cfg_match = '0;
    logic [7:0] cfg_replace = '0;

    logic       in_ready, out_valid;
    logic [7:0] out_char;
    logic       in_ready_d, out_valid_d;
    logic [7:0] out_char_d;
`ifdef CHAR_XLAT_STATS_EN
    logic [15:0] match_count, match_count_d;
`endif

    always #5 clk = ~clk;

    seq_char_translator #(.PASS_UNMATCHED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_match(cfg_match), .cfg_replace(cfg_replace)
`ifdef CHAR_XLAT_STATS_EN
        , .match_count(match_count)
`endif
    );

    seq_char_translator #(.PASS_UNMATCHED(1'b0)) dut_d (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_d), .in_char(in_char),
        .out_valid(out_valid_d), .out_ready(out_ready), .out_char(out_char_d),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_match(cfg_match), .cfg_replace(cfg_replace)
`ifdef CHAR_XLAT_STATS_EN
        , .match_count(match_count_d)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: rule list, escape flag and the one pending output.
    bit       m_en  [4];
    bit [7:0] m_mat [4];
    bit [7:0] m_rep [4];
    bit       m_esc;
    bit       m_valid;
    bit [7:0] m_p, m_d;

    logic       obs_ready, obs_valid, obs_ready_d, obs_valid_d;
    logic [7:0] obs_char, obs_char_d;
    bit         exp_ready, exp_valid;
    bit [7:0]   exp_p, exp_d;

    function automatic bit [7:0] xlate(input bit [7:0] ch, input bit pass);
        for (int i = 0; i < 4; i++) begin
            if (m_en[i] && m_mat[i] == ch) return m_rep[i];
        end
        return pass ? ch : 8'h63;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 1'b0; m_mat[i] = 8'h00; m_rep[i] = 8'h00;
        end
        m_en[0] = 1'b1; m_mat[0] = 8'h03; m_rep[0] = 8'h62;
        m_esc = 1'b0; m_valid = 1'b0; m_p = 8'h00; m_d = 8'h00;
    endtask

    // Drives one cycle, samples the DUTs before the edge, then advances the model.
    task automatic step(input bit rst, input bit vin, input bit [7:0] ch, input bit ordy,
                        input bit we, input bit [1:0] idx, input bit en,
                        input bit [7:0] m, input bit [7:0] r);
        bit acc;
        @(negedge clk);
        rst_n = rst; in_valid = vin; in_char = ch; out_ready = ordy;
        cfg_we = we; cfg_idx = idx; cfg_en = en; cfg_match = m; cfg_replace = r;
        #1;
        obs_ready = in_ready;     obs_valid = out_valid;     obs_char = out_char;
        obs_ready_d = in_ready_d; obs_valid_d = out_valid_d; obs_char_d = out_char_d;
        exp_ready = !m_valid || ordy;
        exp_valid = m_valid; exp_p = m_p; exp_d = m_d;
        if (rst) begin
            model_reset();
        end else begin
            acc = vin && exp_ready;
            if (m_valid && ordy) m_valid = 1'b0;
            if (acc) begin
                if (m_esc) begin
                    m_valid = 1'b1; m_p = ch; m_d = ch; m_esc = 1'b0;
                end else if (ch == 8'h1B) begin
                    m_esc = 1'b1;
                end else begin
                    m_valid = 1'b1; m_p = xlate(ch, 1'b1); m_d = xlate(ch, 1'b0);
                end
            end
            if (we) begin
                m_en[idx] = en; m_mat[idx] = m; m_rep[idx] = r;
            end
        end
    endtask

    task automatic send(input bit [7:0] ch, input bit ordy);
        step(1'b0, 1'b1, ch, ordy, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 1'b0, 8'h00, ordy, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        do_reset();
        idle(1'b1);
        n_tests++;
        if (obs_valid !== 1'b0 || obs_valid_d !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b/%b want 0/0", obs_valid, obs_valid_d);
        end
        n_tests++;
        if (obs_char !== 8'h00 || obs_char_d !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_char got %h/%h want 00/00", obs_char, obs_char_d);
        end
        n_tests++;
        if (obs_ready !== 1'b1 || obs_ready_d !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b/%b want 1/1", obs_ready, obs_ready_d);
        end
    endtask

    task automatic test_basic();
        send(8'h03, 1'b1);
        send(8'h41, 1'b1);
        n_tests++;
        if (obs_valid !== 1'b1 || obs_char !== 8'h62) begin
            n_fail++; $display("FAIL basic_rule0 got v=%b %h want v=1 62", obs_valid, obs_char);
        end
        n_tests++;
        if (obs_valid_d !== 1'b1 || obs_char_d !== 8'h62) begin
            n_fail++; $display("FAIL basic_rule0_dflt got v=%b %h want v=1 62", obs_valid_d, obs_char_d);
        end
        idle(1'b1);
        n_tests++;
        if (obs_valid !== 1'b1 || obs_char !== 8'h41) begin
            n_fail++; $display("FAIL basic_pass got v=%b %h want v=1 41", obs_valid, obs_char);
        end
        n_tests++;
        if (obs_valid_d !== 1'b1 || obs_char_d !== 8'h63) begin
            n_fail++; $display("FAIL basic_default got v=%b %h want v=1 63", obs_valid_d, obs_char_d);
        end
        idle(1'b1);
        n_tests++;
        if (obs_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_drain got v=%b want 0", obs_valid);
        end
    endtask

    task automatic test_escape();
        bit [7:0] seq [4] = '{8'h1B, 8'h03, 8'h1B, 8'h1B};
        bit [7:0] got[$];
        bit [7:0] got_d[$];
        for (int i = 0; i < 6; i++) begin
            if (i < 4) send(seq[i], 1'b1);
            else       idle(1'b1);
            if (i > 0 && obs_valid === 1'b1)   got.push_back(obs_char);
            if (i > 0 && obs_valid_d === 1'b1) got_d.push_back(obs_char_d);
        end
        n_tests++;
        if (got.size() != 2 || got_d.size() != 2) begin
            n_fail++; $display("FAIL esc_count got %0d/%0d want 2/2", got.size(), got_d.size());
        end else begin
            n_tests++;
            if (got[0] !== 8'h03 || got[1] !== 8'h1B) begin
                n_fail++; $display("FAIL esc_values got %h %h want 03 1b", got[0], got[1]);
            end
            n_tests++;
            if (got_d[0] !== 8'h03 || got_d[1] !== 8'h1B) begin
                n_fail++; $display("FAIL esc_values_dflt got %h %h want 03 1b", got_d[0], got_d[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        n_tests++;
        if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_char !== 8'h41) begin
            n_fail++; $display("FAIL bp_stall1 got rdy=%b v=%b %h want rdy=0 v=1 41", obs_ready, obs_valid, obs_char);
        end
        send(8'h42, 1'b0);
        n_tests++;
        if (obs_ready !== 1'b0 || obs_valid !== 1'b1 || obs_char !== 8'h41) begin
            n_fail++; $display("FAIL bp_stall2 got rdy=%b v=%b %h want rdy=0 v=1 41", obs_ready, obs_valid, obs_char);
        end
        send(8'h42, 1'b1);
        n_tests++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b1 || obs_char !== 8'h41) begin
            n_fail++; $display("FAIL bp_release got rdy=%b v=%b %h want rdy=1 v=1 41", obs_ready, obs_valid, obs_char);
        end
        idle(1'b1);
        n_tests++;
        if (obs_valid !== 1'b1 || obs_char !== 8'h42) begin
            n_fail++; $display("FAIL bp_second got v=%b %h want v=1 42", obs_valid, obs_char);
        end
        idle(1'b1);
        n_tests++;
        if (obs_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_empty got v=%b want 0", obs_valid);
        end
    endtask

    task automatic test_cfg_same_cycle();
        step(1'b0, 1'b1, 8'h41, 1'b1, 1'b1, 2'd1, 1'b1, 8'h41, 8'h5A);
        send(8'h41, 1'b1);
        n_tests++;
        if (obs_char !== 8'h41 || obs_char_d !== 8'h63) begin
            n_fail++; $display("FAIL cfg_prewrite got %h/%h want 41/63", obs_char, obs_char_d);
        end
        idle(1'b1);
        n_tests++;
        if (obs_valid !== 1'b1 || obs_char !== 8'h5A || obs_char_d !== 8'h5A) begin
            n_fail++; $display("FAIL cfg_newrule got v=%b %h/%h want v=1 5a/5a", obs_valid, obs_char, obs_char_d);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 1'b1, 8'h03, 8'h77);
        send(8'h03, 1'b1);
        idle(1'b1);
        n_tests++;
        if (obs_valid !== 1'b1 || obs_char !== 8'h62) begin
            n_fail++; $display("FAIL cfg_priority got v=%b %h want v=1 62", obs_valid, obs_char);
        end
    endtask

    task automatic test_reset_midstream();
        send(8'h1B, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00);
        send(8'h03, 1'b1);
        idle(1'b1);
        n_tests++;
        if (obs_valid !== 1'b1 || obs_char !== 8'h62) begin
            n_fail++; $display("FAIL rst_esc_cleared got v=%b %h want v=1 62", obs_valid, obs_char);
        end
        send(8'h41, 1'b1);
        send(8'h1B, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 8'h00);
        idle(1'b0);
        n_tests++;
        if (obs_valid !== 1'b0 || obs_char !== 8'h00) begin
            n_fail++; $display("FAIL rst_held_dropped got v=%b %h want v=0 00", obs_valid, obs_char);
        end
        send(8'h03, 1'b1);
        idle(1'b1);
        n_tests++;
        if (obs_valid !== 1'b1 || obs_char !== 8'h62) begin
            n_fail++; $display("FAIL rst_rule0_restored got v=%b %h want v=1 62", obs_valid, obs_char);
        end
    endtask

    task automatic test_random();
        bit [7:0] pool [5] = '{8'h03, 8'h1B, 8'h41, 8'h5A, 8'h00};
        bit [7:0] ch, m;
        int errs = 0;
        for (int n = 0; n < 600; n++) begin
            ch = pool[$urandom_range(0, 4)];
            if (ch == 8'h00) ch = 8'($urandom);
            m = pool[$urandom_range(0, 3)];
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ch,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                 2'($urandom_range(0, 3)), 1'($urandom), m, 8'($urandom));
            n_tests++;
            if (obs_ready !== exp_ready || obs_valid !== exp_valid || obs_valid_d !== exp_valid ||
                (exp_valid && (obs_char !== exp_p || obs_char_d !== exp_d))) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL rand_step%0d got rdy=%b v=%b/%b %h/%h want rdy=%b v=%b %h/%h",
                             n, obs_ready, obs_valid, obs_valid_d, obs_char, obs_char_d,
                             exp_ready, exp_valid, exp_p, exp_d);
                errs++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_escape();
        test_backpressure();
        test_cfg_same_cycle();
        test_reset_midstream();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_char_translator.md
SEQ_CHAR_TRANSLATOR -- requirements
Module: seq_char_translator

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning character width in bits.
REQ-002 SHALL have parameter NUM_RULES, default 4, meaning number of match/replace rule slots (1..16).
REQ-003 SHALL have parameter PASS_UNMATCHED, default 1: 1 = unmatched chars pass through unchanged; 0 = unmatched chars are replaced by DEFAULT_CHAR.
REQ-004 SHALL have parameter DEFAULT_CHAR, default 8'h63, meaning the replacement for unmatched chars when PASS_UNMATCHED=0.
REQ-005 SHALL have parameter ESC_CHAR, default 8'h1B, meaning the escape character.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-high reset (asserted = 1, despite the name).
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_char (input, DATA_W): the input stream.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_char (output, DATA_W): the output stream.
REQ-010 SHALL have config-write ports: cfg_we (input, 1), cfg_idx (input, $clog2(NUM_RULES)), cfg_en (input, 1), cfg_match (input, DATA_W) and cfg_replace (input, DATA_W).

Function
REQ-011 SHALL accept an input char only on a clk edge with in_valid && in_ready; output transfers only on out_valid && out_ready.
REQ-012 SHALL drive in_ready = !out_valid || out_ready (single output register, full throughput).
REQ-013 SHALL present the translated char on out_char with out_valid high in the cycle after acceptance (latency 1).
REQ-014 SHALL hold out_char and out_valid stable while out_valid && !out_ready.
REQ-015 SHALL translate in state S_NORM by comparing in_char against all enabled rules; the lowest-index matching rule wins and its replace value is output.
REQ-016 SHALL, in S_NORM with no rule match, output in_char if PASS_UNMATCHED=1, else DEFAULT_CHAR.
REQ-017 SHALL, in S_NORM on acceptance of ESC_CHAR, emit nothing (out_valid not set by that char) and move to S_ESC; ESC matching takes priority over rules.
REQ-018 SHALL, in S_ESC, output the next accepted char verbatim (no rule or default applied, including ESC_CHAR itself) and return to S_NORM.
REQ-019 SHALL remain in the current state while no char is accepted.
REQ-020 SHALL, on cfg_we, write {cfg_en, cfg_match, cfg_replace} into slot cfg_idx; cfg_idx >= NUM_RULES is ignored.
REQ-021 SHALL, when a config write and a char acceptance occur in the same cycle, translate that char with the pre-write table; the new rule applies from the next accepted char.

Reset
REQ-022 SHALL, while rst_n=1 at a clk edge, set state=S_NORM, out_valid=0 and out_char=0, discarding any held output and pending escape.
REQ-023 SHALL reset rule 0 to {en=1, match=8'h03, replace=8'h62} and all other rules to en=0, match=0, replace=0.
REQ-024 SHALL drive in_ready=1 in the cycle after reset deasserts.

Configuration
REQ-025 SHALL, when macro CHAR_XLAT_STATS_EN is defined, add output match_count (16 bits), incremented on each accepted char translated by a rule (not escape or default), saturating at 16'hFFFF and cleared by reset.
REQ-026 SHALL, without CHAR_XLAT_STATS_EN, have no match_count port and no counter logic.

Structure
REQ-027 SHALL place the state enum (S_NORM, S_ESC), the rule struct typedef {en, match, replace} and the reset rule-0 constants in package char_xlat_pkg.
REQ-028 SHALL implement the priority rule matcher as combinational sub-module char_rule_match (inputs: rule table and char; outputs: hit and replace value).

Verification
REQ-029 SHALL test: after reset, send 8'h03 then 8'h41 with out_ready=1 -> outputs 8'h62 then 8'h41, each one cycle after acceptance.
REQ-030 SHALL test: with PASS_UNMATCHED=0, send 8'h41 -> output 8'h63.
REQ-031 SHALL test: send 8'h1B, 8'h03, 8'h1B, 8'h1B -> outputs 8'h03 and 8'h1B only.
REQ-032 SHALL test: hold out_ready=0 with 2 chars offered -> in_ready=0 after the first, out_char stable; on out_ready=1 both delivered in order, none lost.
REQ-033 SHALL test: write rule 1 {1, 8'h41, 8'h5A} in the same cycle that 8'h41 is accepted -> output 8'h41, and the next 8'h41 -> 8'h5A; rule 0 and rule 1 both matching 8'h03 -> rule 0 replace value wins.
REQ-034 SHALL test: assert reset while in S_ESC with out_valid=1 -> out_valid=0 next cycle, and a following 8'h03 -> 8'h62.
